// File: rtl/md_arbiter.sv
// md_arbiter: two-requester arbiter and sequencer for the shared HI/LO multiply/divide unit.
// Define MD_ARB_FIXED_PRIO_EN to make req0 win every tie instead of round-robin.
module md_arbiter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] resp_data,
    output logic [3:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    input  logic [31:0] md_do,
    input  logic        md_busy,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0] op;
    logic [31:0] a, b, rdata;
    logic owner, grant, gnt1, op_mul, op_div, op_mf, op_ok;

    assign op_mul = op == 4'd2 || op == 4'd3;
    assign op_div = op == 4'd4 || op == 4'd5;
    assign op_mf  = op == 4'd6 || op == 4'd7;
    assign op_ok  = op != 4'd1 && op < 4'd10;
    assign grant  = state == IDLE && (req0_valid || req1_valid);

`ifdef MD_ARB_FIXED_PRIO_EN
    assign gnt1 = req1_valid && !req0_valid;
`else
    logic last_grant;
    assign gnt1 = req1_valid && (!req0_valid || !last_grant);
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_grant <= 1'b1;
        else if (grant) last_grant <= gnt1;
`endif

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        md_op      = '0;
        md_d1      = '0;
        md_d2      = '0;
        unique case (state)
            IDLE: if (grant) begin
                state_nx   = ISSUE;
                req0_ready = !gnt1;
                req1_ready = gnt1;
            end
            ISSUE: begin
                md_op    = op_ok ? op : 4'd0;
                md_d1    = a;
                md_d2    = b;
                state_nx = (op_mul || op_div) ? WAIT : RESP;
            end
            WAIT: state_nx = (cnt == '0 && !md_busy) ? RESP : WAIT;
            RESP: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner <= gnt1;
                op    <= gnt1 ? req1_op : req0_op;
                a     <= gnt1 ? req1_a : req0_a;
                b     <= gnt1 ? req1_b : req0_b;
            end
            // non-MF ops clear the capture so their done cycle reports 0
            if (state == ISSUE) begin
                cnt   <= op_mul ? CNT_W'(MULT_CYCLES) : op_div ? CNT_W'(DIV_CYCLES) : '0;
                rdata <= op_mf ? md_do : '0;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end

    assign req0_done = state == RESP && !owner;
    assign req1_done = state == RESP && owner;
    assign busy      = state != IDLE;
    assign resp_data = rdata;
endmodule

// File: tb/tb_md_arbiter.sv
// tb_md_arbiter: directed plus randomized checks of md_arbiter against a timestamp-based model.
module tb_md_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] rv = '0;
    logic [1:0][3:0] rop = '0;
    logic [1:0][31:0] ra = '0, rb = '0;
    logic [1:0] rdy, dn;
    logic [31:0] resp_data, md_d1, md_d2, md_do;
    logic [3:0] md_op;
    logic md_busy = 1'b0;
    logic busy;
    logic [31:0] u_hi = '0, u_lo = '0;
    logic rnd = 1'b0;
    int cyc = 0, n_chk = 0, n_fail = 0, op_cycles = 0;
    int order[$];

    md_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(rv[0]), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
        .req0_ready(rdy[0]), .req0_done(dn[0]),
        .req1_valid(rv[1]), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
        .req1_ready(rdy[1]), .req1_done(dn[1]),
        .resp_data(resp_data), .md_op(md_op), .md_d1(md_d1), .md_d2(md_d2),
        .md_do(md_do), .md_busy(md_busy), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // HI/LO effect of one unit operation
    function automatic logic [63:0] unit(input logic [3:0] o, input logic [31:0] x, y, hi, lo);
        logic [63:0] r = {hi, lo};
        case (o)
            4'd2: r = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            4'd3: r = {32'b0, x} * {32'b0, y};
            4'd4: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
            4'd5: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            4'd8: r[63:32] = x;
            4'd9: r[31:0] = x;
            default: ;
        endcase
        return r;
    endfunction

    assign md_do = md_op == 4'd6 ? u_hi : md_op == 4'd7 ? u_lo : '0;
    always @(posedge clk or negedge reset)
        if (!reset) begin u_hi <= '0; u_lo <= '0; end
        else if (md_op != 0) {u_hi, u_lo} <= unit(md_op, md_d1, md_d2, u_hi, u_lo);
    always @(posedge clk) if (md_op != 0) op_cycles <= op_cycles + 1;
    always @(negedge clk) if (reset) begin
        if (rdy[0]) order.push_back(0);
        if (rdy[1]) order.push_back(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, tracked by grant and completion timestamps
    logic m_act = 1'b0, m_last = 1'b1, m_own = 1'b0;
    logic [3:0] m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
    int m_g = 0, m_done = 0, m_early = 0;

    always @(negedge clk) begin
        logic [1:0] e_rdy, e_dn;
        logic [3:0] e_op;
        logic [31:0] e_d1, e_d2;
        logic w, slow;
        if (!reset) begin
            m_act = 1'b0; m_last = 1'b1; m_hi = '0; m_lo = '0;
            chk("reset_ctrl", {rdy, dn, busy, md_op}, 0);
            chk("reset_data", resp_data | md_d1 | md_d2, 0);
        end else begin
`ifdef MD_ARB_FIXED_PRIO_EN
            w = (rv == 2'b10);
`else
            w = (rv == 2'b10) ? 1'b1 : (rv == 2'b01) ? 1'b0 : !m_last;
`endif
            e_rdy = '0; e_dn = '0; e_op = '0; e_d1 = '0; e_d2 = '0;
            if (!m_act && rv != 0) e_rdy[w] = 1'b1;
            if (m_act && cyc == m_g + 1) begin
                e_op = (m_op == 4'd1 || m_op >= 4'd10) ? 4'd0 : m_op;
                e_d1 = m_a;
                e_d2 = m_b;
            end
            if (m_act && cyc == m_done) e_dn[m_own] = 1'b1;
            chk("ready", rdy, e_rdy);
            chk("done", dn, e_dn);
            chk("busy", busy, m_act);
            chk("md_op", md_op, e_op);
            chk("md_d1", md_d1, e_d1);
            chk("md_d2", md_d2, e_d2);
            if (e_dn != 0) chk("resp_data", resp_data, m_op == 4'd6 ? m_hi : m_op == 4'd7 ? m_lo : 32'd0);
            if (!m_act) begin
                if (rv != 0) begin
                    slow = m_op inside {4'd2, 4'd3, 4'd4, 4'd5};
                    m_act = 1'b1; m_own = w; m_last = w; m_g = cyc;
                    m_op = rop[w]; m_a = ra[w]; m_b = rb[w];
                    slow = m_op inside {4'd2, 4'd3, 4'd4, 4'd5};
                    m_early = cyc + 2 + (m_op inside {4'd2, 4'd3} ? 5 : m_op inside {4'd4, 4'd5} ? 10 : 0);
                    m_done = slow ? 0 : cyc + 2;
                end
            end else if (cyc == m_done) begin
                m_act = 1'b0;
            end else begin
                if (cyc == m_g + 1) {m_hi, m_lo} = unit(m_op, m_a, m_b, m_hi, m_lo);
                if (m_done == 0 && cyc >= m_early && !md_busy) m_done = cyc + 1;
            end
        end
    end

    task automatic wait_done(input int r, input int gc, output int lat);
        int n = 0;
        @(negedge clk);
        while (!dn[r] && n < 300) begin @(negedge clk); n++; end
        if (!dn[r]) begin n_chk++; n_fail++; $display("FAIL done_timeout req%0d", r); end
        lat = cyc - gc;
    endtask

    task automatic do_req(input int r, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int gc, output int lat, output logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        rv[r] = 1'b1; rop[r] = o; ra[r] = x; rb[r] = y;
        @(negedge clk);
        while (!rdy[r] && n < 300) begin @(negedge clk); n++; end
        if (!rdy[r]) begin n_chk++; n_fail++; $display("FAIL grant_timeout req%0d", r); end
        gc = cyc;
        @(posedge clk); #1;
        rv[r] = 1'b0;
        wait_done(r, gc, lat);
        d = resp_data;
    endtask

    task automatic rproc(input int r);
        int gc, lat;
        logic [31:0] d;
        repeat (30) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                rv[r] = 1'b1; rop[r] = 4'($urandom_range(0, 15)); ra[r] = $urandom; rb[r] = $urandom;
                @(negedge clk);
                gc = cyc;
                d = {31'b0, rdy[r]};
                @(posedge clk); #1;
                rv[r] = 1'b0;
                if (d[0]) wait_done(r, gc, lat);
            end else begin
                do_req(r, 4'($urandom_range(0, 15)), $urandom, $urandom, gc, lat, d);
            end
        end
    endtask

    function automatic int ord(input int i);
        return i < order.size() ? order[i] : 9;
    endfunction

    initial begin
        int gc0, gc1, l0, l1, k, oc;
        logic [31:0] d0, d1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        do_req(0, 4'd8, 32'h1234_5678, 32'd0, gc0, l0, d0);
        chk("mthi_lat", l0, 2);
        do_req(0, 4'd6, 32'd0, 32'd0, gc0, l0, d0);
        chk("mfhi_lat", l0, 2);
        chk("mfhi_data", d0, 32'h1234_5678);
        oc = op_cycles;
        do_req(0, 4'd2, 32'hFFFF_FFFD, 32'd7, gc0, l0, d0);
        chk("mult_lat", l0, 8);
        chk("mult_issue_cycles", op_cycles - oc, 1);
        chk("mult_resp", d0, 0);
        do_req(0, 4'd7, 32'd0, 32'd0, gc0, l0, d0);
        chk("mflo_mult", d0, 32'hFFFF_FFEB);
        do_req(0, 4'd6, 32'd0, 32'd0, gc0, l0, d0);
        chk("mfhi_mult", d0, 32'hFFFF_FFFF);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        fork
            do_req(0, 4'd5, 32'd100, 32'd7, gc0, l0, d0);
            do_req(1, 4'd9, 32'd5, 32'd0, gc1, l1, d1);
        join
        chk("divu_lat", l0, 13);
        chk("mtlo_lat", l1, 2);
        chk("req1_grant_after", gc1 - gc0, 14);
        do_req(1, 4'd7, 32'd0, 32'd0, gc1, l1, d1);
        chk("mflo_5", d1, 32'd5);
        k = order.size();
        fork
            repeat (2) do_req(0, 4'd9, 32'd1, 32'd0, gc0, l0, d0);
            repeat (2) do_req(1, 4'd9, 32'd2, 32'd0, gc1, l1, d1);
        join
`ifdef MD_ARB_FIXED_PRIO_EN
        chk("grant_order", {ord(k), ord(k + 1), ord(k + 2), ord(k + 3)}, {32'd0, 32'd0, 32'd1, 32'd1});
`else
        chk("grant_order", {ord(k), ord(k + 1), ord(k + 2), ord(k + 3)}, {32'd0, 32'd1, 32'd0, 32'd1});
`endif
        @(posedge clk); #1;
        rv[0] = 1'b1; rop[0] = 4'd4; ra[0] = 32'd50; rb[0] = 32'd3;
        @(negedge clk);
        chk("div_grant", rdy[0], 1);
        @(posedge clk); #1 rv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 chk("busy_in_wait", busy, 1);
        reset = 1'b0;
        #1 chk("async_reset", {busy, md_op, rdy, dn}, 0);
        @(posedge clk); #1 reset = 1'b1;
        do_req(1, 4'd8, 32'h0000_00A5, 32'd0, gc1, l1, d1);
        chk("post_reset_mthi_lat", l1, 2);
        oc = op_cycles;
        do_req(0, 4'hF, 32'd1, 32'd2, gc0, l0, d0);
        chk("illegal_lat", l0, 2);
        chk("illegal_resp", d0, 0);
        chk("illegal_md_op", op_cycles - oc, 0);
        @(posedge clk); #1 md_busy = 1'b1;
        fork
            do_req(0, 4'd3, 32'd3, 32'd4, gc0, l0, d0);
            begin repeat (11) @(posedge clk); #1 md_busy = 1'b0; end
        join
        chk("busy_stall_lat", l0, 11);
        rnd = 1'b1;
        fork
            begin
                fork rproc(0); rproc(1); join
                rnd = 1'b0;
            end
            begin
                while (rnd) begin @(posedge clk); #1 md_busy = ($urandom_range(0, 3) == 0); end
                md_busy = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/md_arbiter.md
Name: md_arbiter

Overview:
Two-requester arbiter and sequencer for the shared multiply/divide (HI/LO) unit.
- Requesters: pipeline E-stage = req0, auxiliary coprocessor port = req1.
- Accepts one operation at a time and forwards it to the unit for exactly one cycle.
- Tracks unit latency with an internal counter plus the unit's busy flag.
- Returns a done pulse and read data to the owning requester.

Parameters:
- MULT_CYCLES, 5: unit cycles for MULT/MULTU.
- DIV_CYCLES, 10: unit cycles for DIV/DIVU.
- CNT_W, 4: latency counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  request pending; held with payload until req0_ready.
- req0_op  in  4  op code.
- req0_a  in  32  operand 1.
- req0_b  in  32  operand 2.
- req0_ready  out  1  one-cycle grant/accept pulse.
- req0_done  out  1  one-cycle completion pulse.
- req1_valid, req1_op, req1_a, req1_b, req1_ready, req1_done: same as req0.
- resp_data  out  32  MFHI/MFLO result; valid while *_done.
- md_op  out  4  op to unit; non-zero only in ISSUE.
- md_d1  out  32  operand 1 to unit.
- md_d2  out  32  operand 2 to unit.
- md_do  in  32  unit read data (combinational on md_op).
- md_busy  in  1  unit busy flag.
- busy  out  1  arbiter not IDLE.

Behaviour:
- Op codes: 0 none, 2 MULT, 3 MULTU, 4 DIV, 5 DIVU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO.
- Illegal codes are 1, 10-15.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counter = 0; last_grant = 1, so req0 wins the first tie.
  - All outputs 0, resp_data 0.
  - Reset mid-operation aborts it: no done pulse. The unit's own reset is tied to the system reset.

States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any valid: grant the single valid requester.
  - If both are valid: grant the requester != last_grant (round-robin).
  - The granted *_ready is asserted combinationally in this cycle.
  - Latch owner, op, a, b; update last_grant; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - md_op = latched op; md_d1 = a; md_d2 = b.
  - Illegal op: md_op is driven 0.
  - MFHI/MFLO: capture md_do into resp_data at the end of the cycle.
  - MULT/MULTU: load counter with MULT_CYCLES, go to WAIT.
  - DIV/DIVU: load counter with DIV_CYCLES, go to WAIT.
  - All other ops: go to RESP.
- WAIT:
  - md_op = md_d1 = md_d2 = 0.
  - Decrement the counter each cycle while it is non-zero.
  - Leave for RESP only when counter == 0 and md_busy == 0.
  - md_busy stuck high means remain in WAIT indefinitely; there is no timeout.
- RESP (1 cycle):
  - The owner's *_done = 1.
  - resp_data = captured value for MF ops, otherwise 0.
  - Go to IDLE.
  - resp_data holds its value until the next capture.
- Latency, with the grant cycle = cycle 0:
  - MTHI/MTLO/MF ops/illegal: done in cycle 2.
  - MULT/MULTU: done in cycle MULT_CYCLES+3 = 8.
  - DIV/DIVU: done in cycle DIV_CYCLES+3 = 13.
- Back-to-back: a requester valid during its own done cycle is eligible in the following IDLE cycle.
- Minimum spacing between grants is 3 cycles.
- Non-owner requests wait with valid held; ready is never asserted outside IDLE.
- Requester side: valid dropped before ready means the request is withdrawn, with no side effect.

Optional Feature:
- Macro: MD_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins ties; last_grant is unused.
- Undefined: round-robin as specified above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
1. req0 MTHI a=0x12345678, then req0 MFHI -> MTHI done in cycle 2; MFHI done with resp_data=0x12345678.
2. req0 MULT a=0xFFFFFFFD b=7 -> md_op=2 for one cycle, done in cycle 8; then MFLO -> 0xFFFFFFEB, MFHI -> 0xFFFFFFFF.
3. Both valid after reset: req0 DIVU 100/7, req1 MTLO 5:
   - req0 is granted first and done in cycle 13.
   - req1_ready stays low until the next IDLE; req1 done 2 cycles after its grant.
   - Subsequent MFLO returns 5.
4. Both hold valid with MTLO continuously -> grants alternate 0,1,0,1.
   - With MD_ARB_FIXED_PRIO_EN defined -> req0 is granted every time.
5. reset=0 asserted in WAIT of a DIV -> busy, md_op, and all done/ready outputs go 0 immediately, with no done pulse.
   - After release, a req1 MTHI completes in cycle 2.
6. req0 op=4'hF -> md_op stays 0 through ISSUE; done in cycle 2 with resp_data=0.
   - Also: md_busy held high after counter expiry keeps the arbiter in WAIT; done occurs in the cycle after md_busy drops.
